// File: rtl/depacketizer_var.sv
// Flit-serial depacketizer: reassembles 1..MAX_FLITS-flit packets into one wide word.
// Malformed packets (orphan body/tail, aborted or overlength) are dropped and counted.
module depacketizer_var #(
    parameter int WIDTH_FLIT       = 36,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int MAX_FLITS        = 4,
    parameter int WIDTH_CNT        = 16,
    localparam int FLIT_DATA  = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH,
    localparam int HEAD_DATA  = FLIT_DATA - ADDRESS_WIDTH,
    localparam int WIDTH_DATA = HEAD_DATA + (MAX_FLITS - 1) * FLIT_DATA,
    localparam int WIDTH_N    = $clog2(MAX_FLITS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_FLIT-1:0]       data_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [WIDTH_DATA-1:0]       data_out,
    output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
    output logic [WIDTH_N-1:0]          nflits_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        err_out,
    output logic [WIDTH_CNT-1:0]        drop_count
);

    localparam logic [WIDTH_N-1:0] MAX_CNT = WIDTH_N'(MAX_FLITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DROP
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                        w_fv;
    logic                        w_head;
    logic                        w_tail;
    logic [VC_ADDRESS_WIDTH-1:0] w_vc;
    logic [FLIT_DATA-1:0]        w_payload;
    logic                        w_ready;
    logic                        w_take;

    logic [WIDTH_DATA-1:0]       r_buf;
    logic [WIDTH_N-1:0]          r_cnt;
    logic [VC_ADDRESS_WIDTH-1:0] r_vc;

    logic [WIDTH_DATA-1:0]       r_data_out;
    logic [VC_ADDRESS_WIDTH-1:0] r_vc_out;
    logic [WIDTH_N-1:0]          r_nflits_out;
    logic                        r_valid_out;
    logic                        r_err;
    logic [WIDTH_CNT-1:0]        r_drop_count;

    logic [WIDTH_DATA-1:0]       w_head_word;
    logic [WIDTH_DATA-1:0]       w_body_word;

    logic                        w_start;
    logic                        w_err;
    logic                        w_deliver;
    logic                        w_load_head;
    logic                        w_load_body;
    logic [WIDTH_DATA-1:0]       w_deliver_data;
    logic [WIDTH_N-1:0]          w_deliver_n;
    logic [VC_ADDRESS_WIDTH-1:0] w_deliver_vc;

    assign w_fv      = data_in[WIDTH_FLIT-1];
    assign w_head    = data_in[WIDTH_FLIT-2];
    assign w_tail    = data_in[WIDTH_FLIT-3];
    assign w_vc      = data_in[WIDTH_FLIT-4 -: VC_ADDRESS_WIDTH];
    assign w_payload = data_in[FLIT_DATA-1:0];

    // Backpressure depends only on the output register, never on the incoming flit.
    assign w_ready = !r_valid_out || ready_in;
    assign w_take  = valid_in && w_ready && w_fv;

    // Head flit contributes only its low payload bits; the address field is stripped.
    always_comb begin
        w_head_word = '0;
        w_head_word[HEAD_DATA-1:0] = w_payload[HEAD_DATA-1:0];
    end

    // Body flit number r_cnt lands in its own FLIT_DATA-wide slot above the head data.
    always_comb begin
        w_body_word = '0;
        for (int k = 1; k < MAX_FLITS; k++) begin
            if (r_cnt == WIDTH_N'(k)) begin
                w_body_word[HEAD_DATA + (k - 1) * FLIT_DATA +: FLIT_DATA] = w_payload;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_start        = 1'b0;
        w_err          = 1'b0;
        w_deliver      = 1'b0;
        w_load_head    = 1'b0;
        w_load_body    = 1'b0;
        w_deliver_data = w_head_word;
        w_deliver_n    = WIDTH_N'(1);
        w_deliver_vc   = w_vc;

        if (w_take) begin
            case (r_state)
                S_COLLECT: begin
                    if (w_head) begin
                        w_err   = 1'b1;
                        w_start = 1'b1;
                    end else if (w_tail) begin
                        w_deliver      = 1'b1;
                        w_deliver_data = r_buf | w_body_word;
                        w_deliver_n    = r_cnt + WIDTH_N'(1);
                        w_deliver_vc   = r_vc;
                        w_state_next   = S_IDLE;
                    end else if ((r_cnt + WIDTH_N'(1)) < MAX_CNT) begin
                        w_load_body = 1'b1;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = S_DROP;
                    end
                end
                S_DROP: begin
                    if (w_head) begin
                        w_start = 1'b1;
                    end else if (w_tail) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    if (w_head) begin
                        w_start = 1'b1;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = w_tail ? S_IDLE : S_DROP;
                    end
                end
            endcase

            // A head flit always (re)starts a packet, whatever state it arrived in.
            if (w_start) begin
                if (w_tail) begin
                    w_deliver    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (MAX_FLITS > 1) begin
                    w_load_head  = 1'b1;
                    w_state_next = S_COLLECT;
                end else begin
                    w_err        = 1'b1;
                    w_state_next = S_DROP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_vc  <= '0;
        end else if (w_load_head) begin
            r_buf <= w_head_word;
            r_cnt <= WIDTH_N'(1);
            r_vc  <= w_vc;
        end else if (w_load_body) begin
            r_buf <= r_buf | w_body_word;
            r_cnt <= r_cnt + WIDTH_N'(1);
        end
    end

    // A new delivery can coincide with the downstream taking the previous word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out  <= 1'b0;
            r_data_out   <= '0;
            r_vc_out     <= '0;
            r_nflits_out <= '0;
        end else if (w_deliver) begin
            r_valid_out  <= 1'b1;
            r_data_out   <= w_deliver_data;
            r_vc_out     <= w_deliver_vc;
            r_nflits_out <= w_deliver_n;
        end else if (ready_in) begin
            r_valid_out  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err        <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_err <= w_err;
            if (w_err && (r_drop_count != {WIDTH_CNT{1'b1}})) begin
                r_drop_count <= r_drop_count + WIDTH_CNT'(1);
            end
        end
    end

    assign ready_out  = w_ready;
    assign data_out   = r_data_out;
    assign vc_out     = r_vc_out;
    assign nflits_out = r_nflits_out;
    assign valid_out  = r_valid_out;
    assign err_out    = r_err;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_depacketizer_var.sv
// Bench for depacketizer_var: directed scenarios plus randomized traffic checked
// against a packet-level reference model built from flit queues.
module tb_depacketizer_var;

    localparam int W    = 36;
    localparam int FD   = 32;
    localparam int HD   = 28;
    localparam int MAXF = 4;
    localparam int WD   = 124;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  data_in;
    logic          valid_in;
    logic          ready_out;
    logic [WD-1:0] data_out;
    logic [0:0]    vc_out;
    logic [2:0]    nflits_out;
    logic          valid_out;
    logic          ready_in;
    logic          err_out;
    logic [15:0]   drop_count;

    depacketizer_var dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .vc_out     (vc_out),
        .nflits_out (nflits_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .err_out    (err_out),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit            m_valid;
    logic [WD-1:0] m_data;
    logic [0:0]    m_vc;
    logic [2:0]    m_n;
    bit            m_err;
    logic [15:0]   m_count;
    logic [W-1:0]  pkt_q[$];
    bit            discarding;
    bit            g_exp_ready;
    logic          g_seen_ready;

    function automatic logic [W-1:0] mk(input bit h, input bit t, input bit vc, input logic [31:0] p);
        return {1'b1, h, t, vc, p};
    endfunction

    task automatic model_clear();
        m_valid = 0; m_data = '0; m_vc = '0; m_n = '0; m_err = 0; m_count = '0;
        pkt_q.delete(); discarding = 0;
    endtask

    // Packet-level view: a packet is the run of flits from a head to a tail.
    task automatic model_flit(input logic [W-1:0] f, output bit dlv, output bit err,
                              output logic [WD-1:0] d, output logic [0:0] v, output int n);
        dlv = 0; err = 0; d = '0; v = '0; n = 0;
        if (!f[35]) return;
        if (f[34]) begin
            if (pkt_q.size() > 0) err = 1;
            pkt_q.delete();
            pkt_q.push_back(f);
            discarding = 0;
        end else if (discarding) begin
            if (f[33]) discarding = 0;
            return;
        end else if (pkt_q.size() == 0) begin
            err = 1;
            discarding = !f[33];
            return;
        end else begin
            pkt_q.push_back(f);
        end
        if (f[33]) begin
            n = pkt_q.size();
            v = pkt_q[0][32];
            d = WD'(pkt_q[0][27:0]);
            for (int k = 1; k < n; k++) d = d | (WD'(pkt_q[k][31:0]) << (HD + FD * (k - 1)));
            dlv = 1;
            pkt_q.delete();
        end else if (pkt_q.size() == MAXF) begin
            err = 1;
            discarding = 1;
            pkt_q.delete();
        end
    endtask

    task automatic cycle(input bit v, input logic [W-1:0] f, input bit rdy);
        bit acc, dlv, err;
        logic [WD-1:0] d;
        logic [0:0] vc;
        int n;
        @(negedge clk);
        valid_in = v; data_in = f; ready_in = rdy;
        #1 g_seen_ready = ready_out;
        g_exp_ready = !m_valid || rdy;
        acc = v && g_exp_ready;
        dlv = 0; err = 0; d = '0; vc = '0; n = 0;
        if (acc) model_flit(f, dlv, err, d, vc, n);
        @(posedge clk);
        if (dlv) begin
            m_valid = 1; m_data = d; m_vc = vc; m_n = 3'(n);
        end else if (rdy) begin
            m_valid = 0;
        end
        m_err = err;
        if (err && m_count != 16'hFFFF) m_count = m_count + 16'd1;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; valid_in = 0; ready_in = 1; data_in = '0;
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        n_checks++; if (data_out !== '0) begin n_errors++; $display("FAIL reset_data got=%h exp=0", data_out); end
        n_checks++; if (nflits_out !== 3'd0 || vc_out !== 1'b0) begin n_errors++; $display("FAIL reset_n_vc got=%0d/%0d exp=0/0", nflits_out, vc_out); end
        n_checks++; if (err_out !== 1'b0 || drop_count !== 16'd0) begin n_errors++; $display("FAIL reset_err got=%b/%0d exp=0/0", err_out, drop_count); end
        n_checks++; if (ready_out !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
    endtask

    task automatic test_single();
        logic [WD-1:0] exp_d;
        exp_d = WD'(28'hABCDEF1);
        cycle(1, mk(1, 1, 0, 32'h5ABCDEF1), 1);
        n_checks++; if (valid_out !== 1'b1) begin n_errors++; $display("FAIL single_valid got=%b exp=1", valid_out); end
        n_checks++; if (data_out !== exp_d) begin n_errors++; $display("FAIL single_data got=%h exp=%h", data_out, exp_d); end
        n_checks++; if (nflits_out !== 3'd1) begin n_errors++; $display("FAIL single_n got=%0d exp=1", nflits_out); end
        cycle(0, '0, 1);
        n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL single_clear got=%b exp=0", valid_out); end
    endtask

    task automatic test_four();
        logic [WD-1:0] exp_d;
        exp_d = WD'(1) | (WD'(2) << 28) | (WD'(3) << 60) | (WD'(4) << 92);
        cycle(1, mk(1, 0, 1, 32'h1), 1);
        cycle(1, mk(0, 0, 1, 32'h2), 1);
        cycle(1, mk(0, 0, 1, 32'h3), 1);
        n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL four_early got=%b exp=0", valid_out); end
        cycle(1, mk(0, 1, 1, 32'h4), 1);
        n_checks++; if (data_out !== exp_d || valid_out !== 1'b1) begin n_errors++; $display("FAIL four_data got=%h exp=%h", data_out, exp_d); end
        n_checks++; if (nflits_out !== 3'd4 || vc_out !== 1'b1) begin n_errors++; $display("FAIL four_n_vc got=%0d/%0d exp=4/1", nflits_out, vc_out); end
        cycle(0, '0, 1);
    endtask

    task automatic test_back_to_back();
        logic [WD-1:0] a, c;
        a = WD'(28'h0000AAA);
        c = WD'(28'h0000CCC);
        cycle(1, mk(1, 1, 0, 32'hAAA), 0);
        for (int i = 0; i < 2; i++) begin
            cycle(1, mk(1, 1, 0, 32'hBBB), 0);
            n_checks++; if (g_seen_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready got=%b exp=0", g_seen_ready); end
            n_checks++; if (data_out !== a || valid_out !== 1'b1) begin n_errors++; $display("FAIL bp_hold got=%h exp=%h", data_out, a); end
        end
        cycle(1, mk(1, 1, 0, 32'hCCC), 1);
        n_checks++; if (g_seen_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release got=%b exp=1", g_seen_ready); end
        n_checks++; if (data_out !== c || valid_out !== 1'b1) begin n_errors++; $display("FAIL b2b_data got=%h exp=%h", data_out, c); end
        cycle(0, '0, 1);
        n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got=%b exp=0", valid_out); end
    endtask

    task automatic test_abort();
        do_reset();
        cycle(1, mk(1, 0, 0, 32'h7), 1);
        cycle(1, mk(0, 0, 0, 32'h8), 1);
        cycle(1, mk(1, 1, 0, 32'h9), 1);
        n_checks++; if (err_out !== 1'b1 || drop_count !== 16'd1) begin n_errors++; $display("FAIL abort_err got=%b/%0d exp=1/1", err_out, drop_count); end
        n_checks++; if (valid_out !== 1'b1 || nflits_out !== 3'd1 || data_out !== WD'(9)) begin n_errors++; $display("FAIL abort_pkt got=%0d/%h exp=1/9", nflits_out, data_out); end
        cycle(0, '0, 1);
        n_checks++; if (err_out !== 1'b0 || drop_count !== 16'd1) begin n_errors++; $display("FAIL abort_pulse got=%b/%0d exp=0/1", err_out, drop_count); end
    endtask

    task automatic test_overlength();
        do_reset();
        cycle(1, mk(1, 0, 0, 32'h11), 1);
        cycle(1, mk(0, 0, 0, 32'h12), 1);
        cycle(1, mk(0, 0, 0, 32'h13), 1);
        cycle(1, mk(0, 0, 0, 32'h14), 1);
        n_checks++; if (err_out !== 1'b1 || valid_out !== 1'b0) begin n_errors++; $display("FAIL ovl_err got=%b/%b exp=1/0", err_out, valid_out); end
        cycle(1, mk(0, 0, 0, 32'h15), 1);
        cycle(1, mk(0, 1, 0, 32'h16), 1);
        n_checks++; if (err_out !== 1'b0 || valid_out !== 1'b0) begin n_errors++; $display("FAIL ovl_drop got=%b/%b exp=0/0", err_out, valid_out); end
        cycle(1, mk(1, 0, 0, 32'h21), 1);
        cycle(1, mk(0, 1, 0, 32'h22), 1);
        n_checks++; if (valid_out !== 1'b1 || nflits_out !== 3'd2 || data_out !== (WD'(32'h21) | (WD'(32'h22) << 28))) begin n_errors++; $display("FAIL ovl_next got=%0d/%h exp=2", nflits_out, data_out); end
        n_checks++; if (drop_count !== 16'd1) begin n_errors++; $display("FAIL ovl_count got=%0d exp=1", drop_count); end
    endtask

    task automatic test_reset_mid();
        cycle(1, mk(1, 0, 1, 32'h31), 1);
        cycle(1, mk(0, 0, 1, 32'h32), 1);
        do_reset();
        n_checks++; if (valid_out !== 1'b0 || data_out !== '0 || nflits_out !== 3'd0 || err_out !== 1'b0 || drop_count !== 16'd0) begin n_errors++; $display("FAIL rstmid_outs got=%b/%h/%0d/%b/%0d exp=all0", valid_out, data_out, nflits_out, err_out, drop_count); end
        cycle(1, mk(0, 1, 0, 32'h33), 1);
        n_checks++; if (err_out !== 1'b1 || valid_out !== 1'b0) begin n_errors++; $display("FAIL rstmid_orphan got=%b/%b exp=1/0", err_out, valid_out); end
        cycle(1, mk(1, 1, 0, 32'h34), 1);
        n_checks++; if (valid_out !== 1'b1 || nflits_out !== 3'd1 || data_out !== WD'(32'h34)) begin n_errors++; $display("FAIL rstmid_clean got=%0d/%h exp=1/34", nflits_out, data_out); end
    endtask

    task automatic test_random();
        logic [W-1:0] f;
        bit v, r;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            f = {($urandom_range(7) != 0), ($urandom_range(2) == 0), ($urandom_range(2) == 0),
                 1'($urandom), 32'($urandom)};
            v = ($urandom_range(3) != 0);
            r = ($urandom_range(3) != 0);
            cycle(v, f, r);
            n_checks++; if (g_seen_ready !== g_exp_ready) begin n_errors++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, g_seen_ready, g_exp_ready); end
            n_checks++; if (valid_out !== m_valid) begin n_errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, valid_out, m_valid); end
            n_checks++; if (data_out !== m_data) begin n_errors++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, data_out, m_data); end
            n_checks++; if (vc_out !== m_vc || nflits_out !== m_n) begin n_errors++; $display("FAIL rnd_vc_n i=%0d got=%0d/%0d exp=%0d/%0d", i, vc_out, nflits_out, m_vc, m_n); end
            n_checks++; if (err_out !== m_err) begin n_errors++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, err_out, m_err); end
            n_checks++; if (drop_count !== m_count) begin n_errors++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, drop_count, m_count); end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 65534; i++) cycle(1, mk(0, 1, 0, 32'h0), 1);
        n_checks++; if (drop_count !== 16'hFFFE) begin n_errors++; $display("FAIL sat_pre got=%h exp=FFFE", drop_count); end
        cycle(1, mk(0, 1, 0, 32'h0), 1);
        n_checks++; if (drop_count !== 16'hFFFF) begin n_errors++; $display("FAIL sat_reach got=%h exp=FFFF", drop_count); end
        for (int i = 0; i < 3; i++) cycle(1, mk(0, 1, 0, 32'h0), 1);
        n_checks++; if (drop_count !== 16'hFFFF || err_out !== 1'b1) begin n_errors++; $display("FAIL sat_hold got=%h/%b exp=FFFF/1", drop_count, err_out); end
    endtask

    initial begin
        rst = 1; valid_in = 0; ready_in = 1; data_in = '0;
        model_clear();
        test_reset();
        test_single();
        test_four();
        test_back_to_back();
        test_abort();
        test_overlength();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
